s27_bist_ctrl: RTL and testbench
================================

Name: s27_bist_ctrl

Overview:
- Built-in self-test sequencer for one s27 core instance; shares the core's CK.
- On START, drives a fixed two-cycle initialization sequence onto G0..G3, which puts s27 state (G5,G6,G7) at (0,1,0).
- Then applies NUM_VEC pseudo-random vectors from a 4-bit LFSR and compacts the G17 response into an 8-bit MISR.
- Reports DONE, and PASS when the signature matches EXP_SIG.

Parameters:
NUM_VEC, 15, number of LFSR vectors applied (0..255).
SEED, 4'b0001, LFSR start value; must be nonzero.

Ports:
CK  input  1  clock, shared with the s27 core.
RN  input  1  synchronous active-low reset.
START  input  1  begin a test run; sampled only in IDLE or DONE.
EXP_SIG  input  8  expected signature.
G17  input  1  s27 output; combinational function of core state and current G0..G3.
G0  output  1  s27 input 0, registered.
G1  output  1  s27 input 1, registered.
G2  output  1  s27 input 2, registered.
G3  output  1  s27 input 3, registered.
BUSY  output  1  high in INIT0, INIT1 and APPLY.
DONE  output  1  high in the DONE state.
PASS  output  1  registered (SIG==EXP_SIG), updated on entry to DONE.
SIG  output  8  current MISR contents.

Behaviour:
- Reset (RN=0 at a CK edge), including mid-run:
  - state to IDLE.
  - G0..G3=0, BUSY=0, DONE=0, PASS=0, SIG=0, LFSR=SEED, count=0.
- State IDLE: outputs hold 0.
  - START=1 -> INIT0; SIG cleared, LFSR loaded with SEED, count cleared on the same edge.
- State INIT0: (G0,G1,G2,G3)=(0,0,1,1) for one cycle -> INIT1.
- State INIT1: (G0,G1,G2,G3)=(1,0,1,1) for one cycle.
  - If NUM_VEC=0 -> DONE, with no MISR update.
  - Otherwise -> APPLY.
- State APPLY: G0=L[0], G1=L[1], G2=L[2], G3=L[3], where L is the current LFSR value.
  - At each CK edge in APPLY: MISR shifts in G17, LFSR advances, count increments.
  - When count reaches NUM_VEC-1 at an edge -> DONE.
  - Exactly NUM_VEC vectors are applied and NUM_VEC G17 samples are captured.
- State DONE: G0..G3=0, DONE=1, PASS and SIG held.
  - START=1 -> INIT0, same clearing actions as from IDLE.
- MISR/LFSR timing: G0..G3 are outputs of the registered state/LFSR and G17 is combinational, so G17 is sampled in the same cycle its vector is driven.
- LFSR: next = {L[2:0], L[3]^L[2]}; period 15; from 0001 the sequence is 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8, then 1.
- MISR (poly x^8+x^4+x^3+x^2+1):
  - fb = SIG[7]^G17.
  - next[0] = fb.
  - next[i] = SIG[i-1] for i in {1,5,6,7}.
  - next[i] = SIG[i-1]^fb for i in {2,3,4}.
- BUSY duration: exactly 2+NUM_VEC cycles per run.
- START while BUSY: ignored.
- START held continuously: back-to-back runs; DONE is high for 1 cycle between runs.
- count: 8-bit; NUM_VEC>255 is illegal.
- Any nonzero SEED is legal; SEED=0 is illegal. Sequence wraps after 15 vectors; NUM_VEC>15 repeats vectors and is legal.

Test Plan:
- Reset mid-run: RN=0 during APPLY with NUM_VEC=15 -> next cycle state IDLE, G0..G3=0, BUSY=0, DONE=0, SIG=0x00; a following START produces a full 17-cycle BUSY window.
- Default run with G17 tied 0 and EXP_SIG=0x00:
  - Edge-by-edge from START: vectors 0011-pattern (0,0,1,1), then (1,0,1,1), then LFSR values 1,2,4,9,...,8 on {G3,G2,G1,G0}.
  - BUSY=1 for 17 cycles, then DONE=1, SIG=0x00, PASS=1.
- NUM_VEC=1, G17 tied 1, EXP_SIG=0x1D -> SIG=0x1D, PASS=1; rerun with EXP_SIG=0x1C -> PASS=0.
- NUM_VEC=2, G17 tied 1 -> SIG=0x27 after the second APPLY edge; NUM_VEC=0 -> DONE 2 cycles after START, SIG=0x00.
- Live s27 core connected:
  - After INIT1, the core state is (G5,G6,G7)=(0,1,0).
  - The 15-vector signature matches a reference-model MISR.
  - START pulsed during BUSY is ignored; START in DONE restarts and reproduces the same SIG.

Source files
------------

// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl - built-in self-test sequencer for a single s27 core.
//
// A run starts when START is seen in IDLE or DONE. The sequencer first
// drives a fixed two-cycle pattern on G0..G3. That pattern forces the
// core state (G5,G6,G7) to (0,1,0) whatever it held before. It then
// applies NUM_VEC vectors from a 4-bit LFSR and folds each G17 response
// into an 8-bit MISR. When the run finishes it raises DONE. PASS reports
// whether the final signature equals EXP_SIG.
//
// Ports:
//   CK       clock, shared with the s27 core
//   RN       synchronous active-low reset
//   START    begin a run (ignored while BUSY)
//   EXP_SIG  expected 8-bit signature
//   G17      s27 response, combinational in core state and G0..G3
//   G0..G3   stimulus to the s27 core
//   BUSY     high during INIT0, INIT1 and APPLY
//   DONE     high while the sequencer sits in DONE
//   PASS     registered signature comparison, updated on entry to DONE
//   SIG      current MISR contents
module s27_bist_ctrl #(
    parameter int unsigned NUM_VEC = 15,
    parameter logic [3:0]  SEED    = 4'b0001
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       START,
    input  logic [7:0] EXP_SIG,
    input  logic       G17,
    output logic       G0,
    output logic       G1,
    output logic       G2,
    output logic       G3,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] SIG
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT0,
        ST_INIT1,
        ST_APPLY,
        ST_DONE
    } state_t;

    // count value on the final APPLY edge; unused when NUM_VEC is zero
    localparam logic [7:0] LAST_CNT = 8'(NUM_VEC - 1);

    state_t     state_q, state_d;
    logic [3:0] lfsr_q, lfsr_d;
    logic [7:0] count_q, count_d;
    logic [7:0] sig_q, sig_d;
    logic       pass_q, pass_d;

    logic [3:0] gVec;
    logic [3:0] lfsrNext;
    logic [7:0] misrNext;
    logic       misrFb;
    logic       busy;
    logic       done;

    // The LFSR and the MISR step are pure functions of the current registers.
    // The MISR uses the polynomial x^8+x^4+x^3+x^2+1. Feedback enters at
    // bit 0 and is also XORed into taps 2, 3 and 4.
    always_comb begin
        lfsrNext = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        misrFb   = sig_q[7] ^ G17;
        misrNext = {sig_q[6], sig_q[5], sig_q[4],
                    sig_q[3] ^ misrFb, sig_q[2] ^ misrFb, sig_q[1] ^ misrFb,
                    sig_q[0], misrFb};
    end

    // Next-state and output decode. The stimulus comes straight from the
    // registered state and LFSR, so the G17 value seen in a cycle belongs
    // to the vector driven in that same cycle. It is captured at the end
    // of that cycle.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        count_d = count_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        gVec    = 4'b0000;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_INIT0;
                    sig_d   = 8'h00;
                    lfsr_d  = SEED;
                    count_d = 8'h00;
                end
            end
            ST_INIT0: begin
                // gVec is {G3,G2,G1,G0}
                gVec    = 4'b1100;
                busy    = 1'b1;
                state_d = ST_INIT1;
            end
            ST_INIT1: begin
                gVec = 4'b1101;
                busy = 1'b1;
                if (NUM_VEC == 0) begin
                    state_d = ST_DONE;
                    pass_d  = (sig_q == EXP_SIG);
                end else begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                gVec    = lfsr_q;
                busy    = 1'b1;
                sig_d   = misrNext;
                lfsr_d  = lfsrNext;
                count_d = count_q + 8'd1;
                if (count_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    pass_d  = (misrNext == EXP_SIG);
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (START) begin
                    state_d = ST_INIT0;
                    sig_d   = 8'h00;
                    lfsr_d  = SEED;
                    count_d = 8'h00;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. RN is sampled on the clock edge, so a reset
    // abandons a run in progress cleanly.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            count_q <= 8'h00;
            sig_q   <= 8'h00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

    assign {G3, G2, G1, G0} = gVec;
    assign BUSY = busy;
    assign DONE = done;
    assign PASS = pass_q;
    assign SIG  = sig_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// tb_s27_bist_ctrl - directed bench for s27_bist_ctrl.
//
// Four sequencer instances with NUM_VEC = 15, 1, 2 and 0 share clock and
// reset. The 15-vector instance can see either a constant 0 on G17 or a
// behavioural s27 core that its own G0..G3 drive. The other instances
// have G17 tied high.
module tb_s27_bist_ctrl;

    logic CK = 1'b0;
    logic RN = 1'b0;

    int total = 0;
    int bad   = 0;

    // ---------------- instance with NUM_VEC = 15 ----------------
    logic       start15 = 1'b0;
    logic [7:0] exp15   = 8'h00;
    logic       g17Sel  = 1'b0;
    logic       g17_15;
    logic       g0_15, g1_15, g2_15, g3_15;
    logic       busy15, done15, pass15;
    logic [7:0] sig15;
    logic [3:0] vec15;

    // ---------------- instance with NUM_VEC = 1 ----------------
    logic       start1 = 1'b0;
    logic [7:0] exp1   = 8'h00;
    logic       g0_1, g1_1, g2_1, g3_1;
    logic       busy1, done1, pass1;
    logic [7:0] sig1;
    logic [3:0] vec1;

    // ---------------- instance with NUM_VEC = 2 ----------------
    logic       start2 = 1'b0;
    logic [7:0] exp2   = 8'h00;
    logic       g0_2, g1_2, g2_2, g3_2;
    logic       busy2, done2, pass2;
    logic [7:0] sig2;

    // ---------------- instance with NUM_VEC = 0 ----------------
    logic       start0 = 1'b0;
    logic [7:0] exp0   = 8'h00;
    logic       g0_0, g1_0, g2_0, g3_0;
    logic       busy0, done0, pass0;
    logic [7:0] sig0;

    // behavioural s27 core, state {G5,G6,G7}, started away from 010
    logic [2:0] coreSt = 3'b101;
    logic [3:0] coreEval;
    logic       coreG17;

    assign vec15 = {g3_15, g2_15, g1_15, g0_15};
    assign vec1  = {g3_1, g2_1, g1_1, g0_1};

    // ISCAS s27 netlist. Returns {G17, nextG5, nextG6, nextG7}; g is {G3,G2,G1,G0}.
    function automatic logic [3:0] s27Eval(input logic [2:0] st, input logic [3:0] g);
        logic g5, g6, g7, g14, g8, g12, g15, g16, g9, g11, g10, g13;
        g5  = st[2];
        g6  = st[1];
        g7  = st[0];
        g14 = ~g[0];
        g8  = g14 & g6;
        g12 = ~(g[1] | g7);
        g15 = g12 | g8;
        g16 = g[3] | g8;
        g9  = ~(g16 & g15);
        g11 = ~(g5 | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g[2] | g12);
        return {~g11, g10, g11, g13};
    endfunction

    // Independent MISR step written directly from the polynomial taps.
    function automatic logic [7:0] misrStep(input logic [7:0] s, input logic d);
        logic [7:0] n;
        logic fb;
        fb   = s[7] ^ d;
        n[0] = fb;
        n[1] = s[0];
        n[2] = s[1] ^ fb;
        n[3] = s[2] ^ fb;
        n[4] = s[3] ^ fb;
        n[5] = s[4];
        n[6] = s[5];
        n[7] = s[6];
        return n;
    endfunction

    // The core runs on the shared clock and is always driven by the
    // 15-vector sequencer.
    assign coreEval = s27Eval(coreSt, vec15);
    assign coreG17  = coreEval[3];
    assign g17_15   = g17Sel ? coreG17 : 1'b0;

    always @(posedge CK) begin
        coreSt <= coreEval[2:0];
    end

    always #5 CK = ~CK;

    s27_bist_ctrl #(.NUM_VEC(15), .SEED(4'b0001)) u15 (
        .CK(CK), .RN(RN), .START(start15), .EXP_SIG(exp15), .G17(g17_15),
        .G0(g0_15), .G1(g1_15), .G2(g2_15), .G3(g3_15),
        .BUSY(busy15), .DONE(done15), .PASS(pass15), .SIG(sig15)
    );

    s27_bist_ctrl #(.NUM_VEC(1), .SEED(4'b0001)) u1 (
        .CK(CK), .RN(RN), .START(start1), .EXP_SIG(exp1), .G17(1'b1),
        .G0(g0_1), .G1(g1_1), .G2(g2_1), .G3(g3_1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .SIG(sig1)
    );

    s27_bist_ctrl #(.NUM_VEC(2), .SEED(4'b0001)) u2 (
        .CK(CK), .RN(RN), .START(start2), .EXP_SIG(exp2), .G17(1'b1),
        .G0(g0_2), .G1(g1_2), .G2(g2_2), .G3(g3_2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .SIG(sig2)
    );

    s27_bist_ctrl #(.NUM_VEC(0), .SEED(4'b0001)) u0 (
        .CK(CK), .RN(RN), .START(start0), .EXP_SIG(exp0), .G17(1'b1),
        .G0(g0_0), .G1(g1_0), .G2(g2_0), .G3(g3_0),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .SIG(sig0)
    );

    // Advance by whole cycles and land 1 ns after the rising edge. Outputs
    // are sampled and inputs driven there.
    task automatic applyStimulus(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge CK);
            #1;
        end
    endtask

    // One comparison: count it, and on mismatch count a failure and report.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Count the cycles the 15-vector instance stays BUSY. The wait is
    // bounded so that a stuck sequencer still reaches the summary line.
    task automatic waitIdle15(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy15) break;
            n++;
            applyStimulus(1);
        end
    endtask

    logic [3:0] lfsrSeq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    initial begin
        int n;
        logic [7:0] refSig;
        logic [2:0] refSt;
        logic [3:0] refEval;

        // Reference signature for the live core. After initialisation the
        // core starts in (0,1,0), and the vectors follow the LFSR sequence.
        refSig = 8'h00;
        refSt  = 3'b010;
        for (int i = 0; i < 15; i++) begin
            refEval = s27Eval(refSt, lfsrSeq[i]);
            refSig  = misrStep(refSig, refEval[3]);
            refSt   = refEval[2:0];
        end
        $display("[TB] reference live signature 0x%02h", refSig);

        // ---------------- reset state ----------------
        applyStimulus(2);
        checkOutput("rst_vec", 32'(vec15), 32'h0);
        checkOutput("rst_busy", 32'(busy15), 32'h0);
        checkOutput("rst_done", 32'(done15), 32'h0);
        checkOutput("rst_pass", 32'(pass15), 32'h0);
        checkOutput("rst_sig", 32'(sig15), 32'h00);
        RN = 1'b1;
        applyStimulus(1);
        checkOutput("idle_busy", 32'(busy15), 32'h0);

        // ---------------- default run, G17 = 0 ----------------
        $display("[TB] default run with G17 tied low");
        exp15 = 8'h00;
        g17Sel = 1'b0;
        start15 = 1'b1;
        applyStimulus(1);
        start15 = 1'b0;
        checkOutput("init0_vec", 32'(vec15), 32'hC);
        checkOutput("init0_busy", 32'(busy15), 32'h1);
        applyStimulus(1);
        checkOutput("init1_vec", 32'(vec15), 32'hD);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("apply_vec%0d", i), 32'(vec15), 32'(lfsrSeq[i]));
            checkOutput($sformatf("apply_busy%0d", i), 32'(busy15), 32'h1);
        end
        applyStimulus(1);
        checkOutput("def_done", 32'(done15), 32'h1);
        checkOutput("def_busy", 32'(busy15), 32'h0);
        checkOutput("def_vec", 32'(vec15), 32'h0);
        checkOutput("def_sig", 32'(sig15), 32'h00);
        checkOutput("def_pass", 32'(pass15), 32'h1);

        // ---------------- reset in the middle of APPLY ----------------
        $display("[TB] reset during APPLY");
        g17Sel = 1'b1;
        start15 = 1'b1;
        applyStimulus(1);
        start15 = 1'b0;
        applyStimulus(4);
        checkOutput("mid_busy", 32'(busy15), 32'h1);
        RN = 1'b0;
        applyStimulus(1);
        checkOutput("mrst_vec", 32'(vec15), 32'h0);
        checkOutput("mrst_busy", 32'(busy15), 32'h0);
        checkOutput("mrst_done", 32'(done15), 32'h0);
        checkOutput("mrst_sig", 32'(sig15), 32'h00);
        checkOutput("mrst_pass", 32'(pass15), 32'h0);
        RN = 1'b1;
        start15 = 1'b1;
        applyStimulus(1);
        start15 = 1'b0;
        waitIdle15(n);
        checkOutput("mrst_busylen", 32'(n), 32'd17);
        checkOutput("mrst_done2", 32'(done15), 32'h1);

        // ---------------- NUM_VEC = 1, G17 = 1 ----------------
        $display("[TB] single vector run");
        exp1 = 8'h1D;
        start1 = 1'b1;
        applyStimulus(1);
        start1 = 1'b0;
        checkOutput("nv1_busy", 32'(busy1), 32'h1);
        applyStimulus(2);
        checkOutput("nv1_vec", 32'(vec1), 32'h1);
        applyStimulus(1);
        checkOutput("nv1_done", 32'(done1), 32'h1);
        checkOutput("nv1_sig", 32'(sig1), 32'h1D);
        checkOutput("nv1_pass", 32'(pass1), 32'h1);
        exp1 = 8'h1C;
        start1 = 1'b1;
        applyStimulus(1);
        start1 = 1'b0;
        checkOutput("nv1_restart_sig", 32'(sig1), 32'h00);
        applyStimulus(3);
        checkOutput("nv1b_sig", 32'(sig1), 32'h1D);
        checkOutput("nv1b_pass", 32'(pass1), 32'h0);

        // ---------------- NUM_VEC = 2, G17 = 1 ----------------
        $display("[TB] two vector run");
        exp2 = 8'h27;
        start2 = 1'b1;
        applyStimulus(1);
        start2 = 1'b0;
        applyStimulus(3);
        checkOutput("nv2_sig_mid", 32'(sig2), 32'h1D);
        checkOutput("nv2_busy_mid", 32'(busy2), 32'h1);
        applyStimulus(1);
        checkOutput("nv2_done", 32'(done2), 32'h1);
        checkOutput("nv2_sig", 32'(sig2), 32'h27);
        checkOutput("nv2_pass", 32'(pass2), 32'h1);

        // ---------------- NUM_VEC = 0 ----------------
        $display("[TB] zero vector run");
        exp0 = 8'h00;
        start0 = 1'b1;
        applyStimulus(1);
        start0 = 1'b0;
        checkOutput("nv0_busy0", 32'(busy0), 32'h1);
        checkOutput("nv0_done0", 32'(done0), 32'h0);
        applyStimulus(1);
        checkOutput("nv0_busy1", 32'(busy0), 32'h1);
        applyStimulus(1);
        checkOutput("nv0_done", 32'(done0), 32'h1);
        checkOutput("nv0_sig", 32'(sig0), 32'h00);
        checkOutput("nv0_pass", 32'(pass0), 32'h1);

        // ---------------- live s27 core ----------------
        $display("[TB] live core run");
        g17Sel = 1'b1;
        exp15 = refSig;
        start15 = 1'b1;
        applyStimulus(1);
        start15 = 1'b0;
        applyStimulus(2);
        checkOutput("core_init_state", 32'(coreSt), 32'b010);
        // a START pulse in the middle of APPLY must change nothing
        start15 = 1'b1;
        applyStimulus(1);
        start15 = 1'b0;
        waitIdle15(n);
        checkOutput("live_busyrest", 32'(n), 32'd14);
        checkOutput("live_done", 32'(done15), 32'h1);
        checkOutput("live_sig", 32'(sig15), 32'(refSig));
        checkOutput("live_pass", 32'(pass15), 32'h1);

        // START held high gives back-to-back runs with one DONE cycle between them
        start15 = 1'b1;
        applyStimulus(1);
        waitIdle15(n);
        checkOutput("b2b_busylen", 32'(n), 32'd17);
        checkOutput("b2b_done", 32'(done15), 32'h1);
        checkOutput("b2b_sig", 32'(sig15), 32'(refSig));
        applyStimulus(1);
        checkOutput("b2b_rebusy", 32'(busy15), 32'h1);
        checkOutput("b2b_redone", 32'(done15), 32'h0);
        start15 = 1'b0;
        waitIdle15(n);
        checkOutput("b2b2_busylen", 32'(n), 32'd17);
        checkOutput("b2b2_sig", 32'(sig15), 32'(refSig));
        checkOutput("b2b2_pass", 32'(pass15), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
